// File: rtl/sram_req_ctrl.sv
// Valid/ready request/response front-end that sequences SRAM CS/WE/addr/data pins.
// Optional power-up zero-fill sweep is enabled by defining SRAM_CTRL_INIT_EN.
module sram_req_ctrl #(
  parameter int unsigned ADDR   = 4,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned LENGTH = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [ADDR-1:0]  req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic             mem_cs,
  output logic             mem_we,
  output logic [ADDR-1:0]  mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             busy
);

  localparam logic [ADDR:0] LEN_W  = LENGTH[ADDR:0];
  localparam logic [2:0]    LAT_M1 = 3'(RD_LAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    RSP
`ifdef SRAM_CTRL_INIT_EN
    , INIT
`endif
  } state_t;

`ifdef SRAM_CTRL_INIT_EN
  localparam state_t      RST_STATE = INIT;
  localparam logic        RST_READY = 1'b0;
  localparam logic [ADDR-1:0] LAST_ADDR = ADDR'(LENGTH - 1);
  logic [ADDR-1:0] init_cnt;
  logic            init_last;
`else
  localparam state_t      RST_STATE = IDLE;
  localparam logic        RST_READY = 1'b1;
`endif

  state_t     state;
  logic [2:0] lat_cnt;
  logic       rd_oor;
  logic       in_range;

  assign in_range = ({1'b0, req_addr} < LEN_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RST_STATE;
      req_ready <= RST_READY;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem_cs    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      lat_cnt   <= '0;
      rd_oor    <= 1'b0;
`ifdef SRAM_CTRL_INIT_EN
      init_cnt  <= '0;
      init_last <= 1'b0;
      busy      <= 1'b0;
`endif
    end else begin
      mem_cs <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            if (req_we) begin
              // Writes never leave IDLE; out-of-range ones are silently dropped.
              if (in_range) begin
                mem_cs    <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= req_addr;
                mem_wdata <= req_wdata;
              end
            end else begin
              state     <= RD_ISSUE;
              req_ready <= 1'b0;
              rd_oor    <= ~in_range;
              if (in_range) begin
                mem_cs   <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= req_addr;
              end
            end
          end
        end
        RD_ISSUE: begin
          state   <= RD_WAIT;
          lat_cnt <= LAT_M1;
        end
        RD_WAIT: begin
          if (lat_cnt == 3'd0) begin
            state     <= RSP;
            rsp_valid <= 1'b1;
            rsp_rdata <= rd_oor ? '0 : mem_rdata;
            rsp_err   <= rd_oor;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        RSP: begin
          if (rsp_valid && rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
          end
        end
`ifdef SRAM_CTRL_INIT_EN
        INIT: begin
          // init_last marks that the final address was issued, since an ADDR-wide
          // counter cannot represent LENGTH when LENGTH == 2**ADDR.
          if (init_last) begin
            state     <= IDLE;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            init_last <= 1'b0;
          end else begin
            busy      <= 1'b1;
            mem_cs    <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= init_cnt;
            mem_wdata <= '0;
            if (init_cnt == LAST_ADDR) init_last <= 1'b1;
            else                       init_cnt  <= init_cnt + 1'b1;
          end
        end
`endif
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

`ifndef SRAM_CTRL_INIT_EN
  assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Directed bench for sram_req_ctrl (LENGTH=12, RD_LAT=1) with a behavioural SRAM attached.
module tb_sram_req_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_we;
  logic [3:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid, rsp_ready, rsp_err;
  logic [7:0] rsp_rdata;
  logic       mem_cs, mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;
  logic       busy;

  int passes = 0;
  int total  = 0;
  int cs_cnt = 0;
  int xfers  = 0;
  logic preload = 1'b0;
  logic [7:0] sram [16];

  always #5 clk = ~clk;

  sram_req_ctrl #(.ADDR(4), .WIDTH(8), .LENGTH(12), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // SRAM model: one-cycle read latency, synchronous write.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) sram[i] <= 8'hFF;
    end else if (mem_cs && mem_we) begin
      sram[mem_addr] <= mem_wdata;
    end
    if (mem_cs && !mem_we) mem_rdata <= sram[mem_addr];
    if (mem_cs) cs_cnt <= cs_cnt + 1;
    if (rsp_valid && rsp_ready) xfers <= xfers + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d, input logic exp_cs);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    tick();
    req_valid = 1'b0;
    chk("wr_cs", mem_cs, exp_cs);
    if (exp_cs) begin
      chk("wr_we", mem_we, 1'b1);
      chk("wr_addr", mem_addr, a);
      chk("wr_data", mem_wdata, d);
    end
    chk("wr_ready", req_ready, 1'b1);
    tick();
    chk("wr_cs_one", mem_cs, 1'b0);
  endtask

  task automatic do_read(input logic [3:0] a, input logic [7:0] exp_d, input logic exp_err);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a; rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("rd_cs", mem_cs, !exp_err);
    chk("rd_we", mem_we, 1'b0);
    chk("rd_ready0", req_ready, 1'b0);
    tick();
    chk("rd_cs_off", mem_cs, 1'b0);
    chk("rd_early", rsp_valid, 1'b0);
    tick();
    chk("rd_valid", rsp_valid, 1'b1);
    chk("rd_data", rsp_rdata, exp_d);
    chk("rd_err", rsp_err, exp_err);
    tick();
    chk("rd_done", rsp_valid, 1'b0);
    chk("rd_ready1", req_ready, 1'b1);
    rsp_ready = 1'b0;
  endtask

  task automatic wait_init();
`ifdef SRAM_CTRL_INIT_EN
    tick();
    for (int i = 0; i < 12; i++) begin
      chk("init_busy", busy, 1'b1);
      chk("init_cs", mem_cs, 1'b1);
      chk("init_addr", mem_addr, i);
      chk("init_data", mem_wdata, 8'h00);
      tick();
    end
    chk("init_done", busy, 1'b0);
    chk("init_ready", req_ready, 1'b1);
`endif
  endtask

  initial begin
    int base;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
`ifdef SRAM_CTRL_INIT_EN
    preload = 1'b1;
`endif
    tick();
    tick();
    preload = 1'b0;
    chk("rst_valid", rsp_valid, 1'b0);
    chk("rst_cs", mem_cs, 1'b0);
    chk("rst_busy", busy, 1'b0);
`ifdef SRAM_CTRL_INIT_EN
    chk("rst_ready", req_ready, 1'b0);
`else
    chk("rst_ready", req_ready, 1'b1);
`endif
    rst = 1'b0;
    wait_init();
`ifdef SRAM_CTRL_INIT_EN
    do_read(4'd7, 8'h00, 1'b0);
`endif

    // Test 1: write then read back
    do_write(4'd3, 8'hA5, 1'b1);
    do_read(4'd3, 8'hA5, 1'b0);

    // Test 2: back-to-back writes
    for (int i = 0; i < 4; i++) begin
      logic [7:0] d;
      d = 8'(8'h11 * (i + 1));
      req_valid = 1'b1; req_we = 1'b1; req_addr = 4'(i); req_wdata = d;
      tick();
      chk("b2b_ready", req_ready, 1'b1);
      chk("b2b_cs", mem_cs, 1'b1);
      chk("b2b_addr", mem_addr, i);
      chk("b2b_data", mem_wdata, d);
    end
    req_valid = 1'b0;
    tick();
    chk("b2b_cs_end", mem_cs, 1'b0);
    do_read(4'd0, 8'h11, 1'b0);
    do_read(4'd1, 8'h22, 1'b0);
    do_read(4'd2, 8'h33, 1'b0);
    do_read(4'd3, 8'h44, 1'b0);
    do_write(4'd3, 8'hA5, 1'b1);

    // Test 3: response back-pressure
    do_write(4'd5, 8'h5A, 1'b1);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd5; rsp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 6; i++) begin
      chk("bp_valid", rsp_valid, 1'b1);
      chk("bp_data", rsp_rdata, 8'h5A);
      chk("bp_ready", req_ready, 1'b0);
      tick();
    end
    base = xfers;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_drop", rsp_valid, 1'b0);
    chk("bp_rdy", req_ready, 1'b1);
    tick();
    chk("bp_xfers", xfers - base, 1);

    // Test 4: address boundary at LENGTH=12
    base = cs_cnt;
    do_write(4'd13, 8'hFF, 1'b0);
    do_read(4'd13, 8'h00, 1'b1);
    do_read(4'd12, 8'h00, 1'b1);
    chk("oor_cs", cs_cnt - base, 0);
    do_write(4'd11, 8'hB1, 1'b1);
    do_read(4'd11, 8'hB1, 1'b0);

    // Test 5: reset after read accept
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd3; rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_cs", mem_cs, 1'b0);
    chk("mid_valid", rsp_valid, 1'b0);
    base = cs_cnt;
    tick();
    tick();
    rst = 1'b0;
`ifdef SRAM_CTRL_INIT_EN
    wait_init();
    do_read(4'd3, 8'h00, 1'b0);
`else
    for (int i = 0; i < 4; i++) begin
      chk("post_valid", rsp_valid, 1'b0);
      tick();
    end
    chk("post_cs", cs_cnt - base, 0);
    do_read(4'd3, 8'hA5, 1'b0);
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
